// File: rtl/fdiv_nr_recip_iter_if.sv
// Handshake bundle for the Newton-Raphson reciprocal refinement block.
// The master offers operations and accepts results; the slave is the refinement unit.
interface fdiv_nr_recip_iter_if #(
  parameter int W      = 24,
  parameter int TAG_W  = 5,
  parameter int ITER_W = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_d;
  logic [W-1:0]      in_seed;
  logic [ITER_W-1:0] in_iters;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_x;
  logic              out_sat;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_d, in_seed, in_iters, in_tag, out_ready,
    input  in_ready, out_valid, out_x, out_sat, out_tag
  );

  modport slave (
    input  in_valid, in_d, in_seed, in_iters, in_tag, out_ready,
    output in_ready, out_valid, out_x, out_sat, out_tag
  );
endinterface

// File: rtl/fdiv_nr_recip_iter.sv
// Iterative Newton-Raphson reciprocal refinement: x' = x*(2 - d*x).
// One W x (W+1) multiplier is time-shared between the d*x and x*e phases,
// so each refinement takes two cycles. All fixed-point values are Q1.(W-1)
// except the error term e, which is Q2.(W-1) so that it can represent 2.0.
module fdiv_nr_recip_iter #(
  parameter int W         = 24,
  parameter int MAX_ITERS = 3,
  parameter int TAG_W     = 5
) (
  input logic                clk,
  input logic                rst,
  fdiv_nr_recip_iter_if.slave bus
);

  localparam int ITER_W = $clog2(MAX_ITERS + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MUL_DX = 2'd1;
  localparam logic [1:0] MUL_XE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [ITER_W-1:0] MAX_N = ITER_W'(MAX_ITERS);
  localparam logic [ITER_W-1:0] ONE_N = ITER_W'(1);
  // 2.0 in Q2.(W-1)
  localparam logic [W:0]        TWO   = {1'b1, {W{1'b0}}};

  logic [1:0]        state_reg;
  logic [W-1:0]      d_reg;
  logic [W-1:0]      x_reg;
  logic [W:0]        e_reg;
  logic [ITER_W-1:0] n_reg;
  logic              sat_reg;
  logic [TAG_W-1:0]  tag_reg;

  logic [W:0]        mul_b;
  logic [2*W:0]      prod;
  logic [W:0]        t;
  logic [W+1:0]      xn;
  logic              t_sat;
  logic              xn_ovf;
  logic [ITER_W-1:0] n_clamped;
  logic              unused_lsbs;

  // Shared multiplier: second operand is d in MUL_DX/IDLE and e in MUL_XE
  always_comb begin
    mul_b = (state_reg == MUL_XE) ? e_reg : {1'b0, d_reg};
    prod  = {{(W+1){1'b0}}, x_reg} * {{W{1'b0}}, mul_b};
  end

  // Rescale the product back to the binary point and detect range overflow
  always_comb begin
    t         = prod[2*W-1:W-1];
    xn        = prod[2*W:W-1];
    t_sat     = (t >= TWO);
    xn_ovf    = (xn[W+1:W] != 2'b00);
    n_clamped = (bus.in_iters > MAX_N) ? MAX_N : bus.in_iters;
  end

  // Fraction bits below the truncation point are dropped on purpose
  assign unused_lsbs = ^prod[W-2:0];

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_x     = x_reg;
  assign bus.out_sat   = sat_reg;
  assign bus.out_tag   = tag_reg;

  // Control FSM and datapath registers; reset silently drops any op in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      d_reg     <= '0;
      x_reg     <= '0;
      e_reg     <= '0;
      n_reg     <= '0;
      sat_reg   <= 1'b0;
      tag_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            d_reg     <= bus.in_d;
            x_reg     <= bus.in_seed;
            tag_reg   <= bus.in_tag;
            n_reg     <= n_clamped;
            sat_reg   <= 1'b0;
            state_reg <= (n_clamped != '0) ? MUL_DX : DONE;
          end
        end
        MUL_DX: begin
          // e = 2 - d*x, floored at zero when d*x has reached 2.0
          if (t_sat) begin
            e_reg   <= '0;
            sat_reg <= 1'b1;
          end else begin
            e_reg   <= TWO - t;
          end
          state_reg <= MUL_XE;
        end
        MUL_XE: begin
          // x = x*e, clamped to the largest Q1.(W-1) value on overflow
          if (xn_ovf) begin
            x_reg   <= '1;
            sat_reg <= 1'b1;
          end else begin
            x_reg   <= xn[W-1:0];
          end
          n_reg     <= n_reg - ONE_N;
          state_reg <= (n_reg != ONE_N) ? MUL_DX : DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_nr_recip_iter.sv
// Directed and randomised checks of the Newton-Raphson reciprocal refinement
// block against an integer reference model of the refinement arithmetic.
module tb_fdiv_nr_recip_iter;

  localparam int W      = 24;
  localparam int TAG_W  = 5;
  localparam int ITER_W = 2;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  fdiv_nr_recip_iter_if #(.W(W), .TAG_W(TAG_W), .ITER_W(ITER_W)) bus ();

  fdiv_nr_recip_iter #(.W(W), .MAX_ITERS(3), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck design still terminates
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, exp);
    end
  endtask

  // Reference: repeated x' = x*(2 - d*x) in plain integer fixed point
  task automatic ref_model(input logic [W-1:0] d, input logic [W-1:0] seed, input int iters,
                           output logic [W-1:0] x, output logic sat);
    longint dd, xx, t, e, xn;
    longint one_w;
    int n;
    one_w = 64'd1 << W;
    dd  = longint'(d);
    xx  = longint'(seed);
    sat = 1'b0;
    n   = (iters > 3) ? 3 : iters;
    for (int i = 0; i < n; i++) begin
      t = (dd * xx) >> (W - 1);
      if (t >= one_w) begin
        e   = 0;
        sat = 1'b1;
      end else begin
        e = one_w - t;
      end
      xn = (xx * e) >> (W - 1);
      if (xn >= one_w) begin
        xx  = one_w - 1;
        sat = 1'b1;
      end else begin
        xx = xn;
      end
    end
    x = xx[W-1:0];
  endtask

  // Offer one op, measure latency, check the result, optionally stall, then pop
  task automatic run_op(input logic [W-1:0] d, input logic [W-1:0] seed, input logic [ITER_W-1:0] iters,
                        input logic [TAG_W-1:0] tag, input int hold, input string nm);
    logic [W-1:0] ex;
    logic         es;
    int           k;
    ref_model(d, seed, int'(iters), ex, es);
    k = 0;
    while (!bus.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_d     = d;
    bus.in_seed  = seed;
    bus.in_iters = iters;
    bus.in_tag   = tag;
    @(negedge clk);
    bus.in_valid = 1'b0;
    k = 1;
    while (!bus.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_latency"}, 64'(k), 64'(1 + 2 * int'(iters)));
    check({nm, "_x"}, 64'(bus.out_x), 64'(ex));
    check({nm, "_sat"}, 64'(bus.out_sat), 64'(es));
    check({nm, "_tag"}, 64'(bus.out_tag), 64'(tag));
    $display("[TB] op %s d=0x%06h seed=0x%06h iters=%0d tag=0x%02h -> x=0x%06h sat=%0d lat=%0d",
             nm, d, seed, iters, tag, bus.out_x, bus.out_sat, k);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({nm, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({nm, "_hold_x"}, 64'(bus.out_x), 64'(ex));
      check({nm, "_hold_tag"}, 64'(bus.out_tag), 64'(tag));
      check({nm, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({nm, "_pop_valid"}, 64'(bus.out_valid), 64'd0);
    check({nm, "_pop_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_d      = '0;
    bus.in_seed   = '0;
    bus.in_iters  = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_x", 64'(bus.out_x), 64'd0);
    check("rst_out_sat", 64'(bus.out_sat), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);

    // Directed cases with hand-derived expectations
    run_op(24'h800000, 24'h800000, 2'd2, 5'h01, 0, "unity");
    check("unity_val", 64'(bus.out_x), 64'h800000);
    run_op(24'hC00000, 24'h500000, 2'd1, 5'h02, 0, "third_i1");
    check("third_i1_val", 64'(bus.out_x), 64'h550000);
    run_op(24'hC00000, 24'h500000, 2'd2, 5'h03, 0, "third_i2");
    check("third_i2_val", 64'(bus.out_x), 64'h555500);
    run_op(24'hC00000, 24'h500000, 2'd3, 5'h04, 0, "third_i3");
    run_op(24'hA00000, 24'h123456, 2'd0, 5'h1A, 0, "zero_iter");
    check("zero_iter_val", 64'(bus.out_x), 64'h123456);
    run_op(24'hFFFFFF, 24'hFFFFFF, 2'd1, 5'h05, 0, "sat_t");
    check("sat_t_val", 64'(bus.out_x), 64'h000000);

    // Stalled consumer, then back-to-back ops with distinct tags
    run_op(24'hC00000, 24'h500000, 2'd2, 5'h11, 10, "stall");
    run_op(24'h900000, 24'h700000, 2'd1, 5'h12, 0, "b2b_a");
    run_op(24'hE00000, 24'h480000, 2'd2, 5'h13, 0, "b2b_b");

    // Reset during the x*e phase aborts the op with no result
    bus.in_valid = 1'b1;
    bus.in_d     = 24'hC00000;
    bus.in_seed  = 24'h500000;
    bus.in_iters = 2'd2;
    bus.in_tag   = 5'h0F;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_result", 64'(bus.out_valid), 64'd0);
    end
    run_op(24'hC00000, 24'h500000, 2'd2, 5'h10, 0, "after_abort");

    // Randomised operands, including out-of-contract divisors and wild seeds
    for (int r = 0; r < 30; r++) begin
      logic [W-1:0]      rd;
      logic [W-1:0]      rs;
      logic [ITER_W-1:0] ri;
      logic [TAG_W-1:0]  rt;
      rd = W'($urandom);
      if ($urandom_range(0, 4) != 0) rd[W-1] = 1'b1;
      rs = W'($urandom);
      if ($urandom_range(0, 1) == 0) rs = {2'b01, rs[W-3:0]};
      ri = ITER_W'($urandom_range(0, 3));
      rt = TAG_W'($urandom);
      run_op(rd, rs, ri, rt, int'($urandom_range(0, 2)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
